// File: rtl/lfsr_roller_pkg.sv
// Shared types and default constants for the LFSR dice roller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lfsr_roller_pkg;

  // Roller control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fibonacci feedback taps (bits 15,13,12,10) and power-up seed
  localparam logic [15:0] DEF_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'hF731;

endpackage

// File: rtl/lfsr_roller_if.sv
// Key-side controls and display-side results of the dice roller.
// Latency: n/a (wiring only).
// Backpressure: none; controls are single-cycle pulses sampled every clock.
interface lfsr_roller_if #(
  parameter int LFSR_W     = 16,
  parameter int OUT_W      = 4,
  parameter int HIST_DEPTH = 4
);
  localparam int SEL_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int CNT_W = $clog2(HIST_DEPTH + 1);

  logic              i_start;
  logic              i_stop;
  logic              i_seed_load;
  logic [LFSR_W-1:0] i_seed;
  logic [SEL_W-1:0]  i_hist_sel;
  logic [OUT_W-1:0]  o_random_out;
  logic              o_busy;
  logic              o_done;
  logic [OUT_W-1:0]  o_hist_out;
  logic [CNT_W-1:0]  o_hist_count;

  // Key/debounce side drives controls and reads results
  modport master (
    output i_start, i_stop, i_seed_load, i_seed, i_hist_sel,
    input  o_random_out, o_busy, o_done, o_hist_out, o_hist_count
  );

  // Roller side
  modport slave (
    input  i_start, i_stop, i_seed_load, i_seed, i_hist_sel,
    output o_random_out, o_busy, o_done, o_hist_out, o_hist_count
  );
endinterface

// File: rtl/lfsr_roller_core.sv
// Fibonacci LFSR register with seed load, single step and all-zero seed guard.
// Latency: load/step visible on the output one clock after the request.
// Backpressure: none; load has priority over step.
module lfsr_core #(
  parameter int                LFSR_W       = 16,
  parameter int                OUT_W        = 4,
  parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hF731
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_step,
  output logic [OUT_W-1:0]  o_value
);

  logic [LFSR_W-1:0] lfsr;

  // Shift register; an all-zero seed would lock up, so it is replaced by the default
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr <= DEFAULT_SEED;
    end else if (i_load) begin
      lfsr <= (i_seed == '0) ? DEFAULT_SEED : i_seed;
    end else if (i_step) begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
    end
  end

  assign o_value = lfsr[OUT_W-1:0];

endmodule

// File: rtl/lfsr_roller.sv
// Dice roller: LFSR advances on a slowing schedule after start, result lands in a history buffer.
// Latency: roll lasts the sum of its intervals; o_done one cycle, history updated the cycle after.
// Backpressure: none; start restarts, stop ends the roll, seed load only honoured when idle.
module lfsr_roller
  import lfsr_roller_pkg::*;
#(
  parameter int                LFSR_W       = 16,
  parameter int                OUT_W        = 4,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(DEF_SEED),
  parameter int                TICK_W       = 21,
  parameter int                FAST_STEPS   = 13,
  parameter int                MAX_INTERVAL = 32,
  parameter int                HIST_DEPTH   = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  lfsr_roller_if.slave bus
);

  localparam int IV_W   = $clog2(MAX_INTERVAL) + 1;
  localparam int TK_W   = TICK_W + IV_W;
  localparam int STEP_W = $clog2(FAST_STEPS + 1);
  localparam int SEL_W  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int CNT_W  = $clog2(HIST_DEPTH + 1);

  state_t            state;
  logic              busy;
  logic              done;
  logic [TK_W-1:0]   tick;
  logic [IV_W-1:0]   interval;
  logic [STEP_W-1:0] steps;
  logic [STEP_W-1:0] steps_inc;
  logic [TK_W-1:0]   tick_end;
  logic              expiry;
  logic              at_max;
  logic              lfsr_step;
  logic              lfsr_load;
  logic [OUT_W-1:0]  rand_out;
  logic [OUT_W-1:0]  hist [HIST_DEPTH];
  logic [CNT_W-1:0]  hist_count;
  logic [OUT_W-1:0]  hist_out;

  // One interval is interval * 2**TICK_W clocks; the last tick value marks expiry
  assign tick_end  = {interval, {TICK_W{1'b0}}} - TK_W'(1);
  assign expiry    = (tick == tick_end);
  assign at_max    = (interval == IV_W'(MAX_INTERVAL));
  assign steps_inc = (steps == '1) ? steps : steps + STEP_W'(1);

  // LFSR requests: start always steps; expiry steps unless it is the final interval
  always_comb begin
    lfsr_step = 1'b0;
    lfsr_load = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          lfsr_step = 1'b1;
        end else if (bus.i_seed_load) begin
          lfsr_load = 1'b1;
        end
      end
      ROLL: begin
        if (bus.i_start) begin
          lfsr_step = 1'b1;
        end else if (!bus.i_stop && expiry && !at_max) begin
          lfsr_step = 1'b1;
        end
      end
      DONE: begin
        if (bus.i_start) begin
          lfsr_step = 1'b1;
        end
      end
      default: begin
        lfsr_step = 1'b0;
      end
    endcase
  end

  lfsr_core #(
    .LFSR_W       (LFSR_W),
    .OUT_W        (OUT_W),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (lfsr_load),
    .i_seed  (bus.i_seed),
    .i_step  (lfsr_step),
    .o_value (rand_out)
  );

  // Roll FSM with its tick/interval/step counters and registered busy/done
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      tick     <= '0;
      interval <= IV_W'(1);
      steps    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            state    <= ROLL;
            busy     <= 1'b1;
            tick     <= '0;
            interval <= IV_W'(1);
            steps    <= '0;
          end
        end
        ROLL: begin
          if (bus.i_start) begin
            tick     <= '0;
            interval <= IV_W'(1);
            steps    <= '0;
          end else if (bus.i_stop) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (expiry) begin
            tick <= '0;
            if (at_max) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              steps <= steps_inc;
              if (steps_inc >= STEP_W'(FAST_STEPS)) begin
                interval <= interval << 1;
              end
            end
          end else begin
            tick <= tick + TK_W'(1);
          end
        end
        DONE: begin
          if (bus.i_start) begin
            state    <= ROLL;
            busy     <= 1'b1;
            tick     <= '0;
            interval <= IV_W'(1);
            steps    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // History shift register, newest result at index 0, written during the DONE cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < HIST_DEPTH; k++) begin
        hist[k] <= '0;
      end
      hist_count <= '0;
    end else if (state == DONE) begin
      for (int k = HIST_DEPTH - 1; k > 0; k--) begin
        hist[k] <= hist[k-1];
      end
      hist[0] <= rand_out;
      if (hist_count != CNT_W'(HIST_DEPTH)) begin
        hist_count <= hist_count + CNT_W'(1);
      end
    end
  end

  // Combinational history read; indices past the buffer read as zero
  always_comb begin
    hist_out = '0;
    if (int'(bus.i_hist_sel) < HIST_DEPTH) begin
      hist_out = hist[bus.i_hist_sel];
    end
  end

  assign bus.o_random_out = rand_out;
  assign bus.o_busy       = busy;
  assign bus.o_done       = done;
  assign bus.o_hist_out   = hist_out;
  assign bus.o_hist_count = hist_count;

endmodule

// File: tb/tb_lfsr_roller.sv
// Directed bench for lfsr_roller with a short tick (4 clocks per unit), 3 fast steps, max interval 8.
// Latency: a full roll is 17 units = 68 clocks from the start edge to o_done.
// Backpressure: none; inputs driven 1 ns after the rising edge, outputs sampled there too.
module tb_lfsr_roller;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic seen;

  logic [15:0] seeds [5] = '{16'h0100, 16'h2000, 16'h0020, 16'h0080, 16'h0200};
  logic [3:0]  res   [5] = '{4'hB, 4'h8, 4'h1, 4'h5, 4'h6};

  always #5 clk = ~clk;

  lfsr_roller_if #(.LFSR_W(16), .OUT_W(4), .HIST_DEPTH(4)) bus ();

  lfsr_roller #(
    .LFSR_W       (16),
    .OUT_W        (4),
    .TAPS         (16'hB400),
    .DEFAULT_SEED (16'hF731),
    .TICK_W       (2),
    .FAST_STEPS   (3),
    .MAX_INTERVAL (8),
    .HIST_DEPTH   (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic load_seed(input logic [15:0] s);
    bus.i_seed      = s;
    bus.i_seed_load = 1'b1;
    step(1);
    bus.i_seed_load = 1'b0;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    step(1);
    bus.i_start = 1'b0;
  endtask

  task automatic hist_at(input int k, input logic [3:0] e, input string tag);
    bus.i_hist_sel = 2'(k);
    #1;
    chk(tag, 32'(bus.o_hist_out), 32'(e));
    bus.i_hist_sel = 2'd0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_stop      = 1'b0;
    bus.i_seed_load = 1'b0;
    bus.i_seed      = 16'h0000;
    bus.i_hist_sel  = 2'd0;
    step(2);
    rst = 1'b0;

    // 1. reset state after idling
    step(10);
    chk("rst_out",   32'(bus.o_random_out), 32'h1);
    chk("rst_busy",  32'(bus.o_busy), 32'h0);
    chk("rst_done",  32'(bus.o_done), 32'h0);
    chk("rst_count", 32'(bus.o_hist_count), 32'h0);

    // 2. full roll from seed 0x0001: intervals 1,1,1,2,4,8 -> done 68 clocks after start
    load_seed(16'h0001);
    pulse_start();
    chk("t2_start_out",  32'(bus.o_random_out), 32'h2);
    chk("t2_start_busy", 32'(bus.o_busy), 32'h1);
    seen = 1'b0;
    for (int i = 1; i <= 67; i++) begin
      step(1);
      seen = seen | bus.o_done;
      if (i == 3)  chk("t2_out_e3",  32'(bus.o_random_out), 32'h2);
      if (i == 4)  chk("t2_out_e4",  32'(bus.o_random_out), 32'h4);
      if (i == 11) chk("t2_out_e11", 32'(bus.o_random_out), 32'h8);
      if (i == 12) chk("t2_out_e12", 32'(bus.o_random_out), 32'h0);
    end
    chk("t2_no_early_done", 32'(seen), 32'h0);
    chk("t2_busy_e67", 32'(bus.o_busy), 32'h1);
    step(1);
    chk("t2_done_e68", 32'(bus.o_done), 32'h1);
    chk("t2_busy_e68", 32'(bus.o_busy), 32'h0);
    chk("t2_result",   32'(bus.o_random_out), 32'h0);
    step(1);
    chk("t2_done_pulse", 32'(bus.o_done), 32'h0);
    chk("t2_count", 32'(bus.o_hist_count), 32'h1);
    hist_at(0, 4'h0, "t2_hist0");

    // 3. stop ten clocks into a roll
    load_seed(16'h0001);
    pulse_start();
    step(9);
    bus.i_stop = 1'b1;
    step(1);
    bus.i_stop = 1'b0;
    chk("t3_done", 32'(bus.o_done), 32'h1);
    chk("t3_busy", 32'(bus.o_busy), 32'h0);
    chk("t3_out",  32'(bus.o_random_out), 32'h8);
    step(1);
    chk("t3_frozen", 32'(bus.o_random_out), 32'h8);
    chk("t3_count",  32'(bus.o_hist_count), 32'h2);
    hist_at(0, 4'h8, "t3_hist0");
    hist_at(1, 4'h0, "t3_hist1");

    // 4. restart at cycle 30; done 68 clocks after the second start, single history write
    load_seed(16'h0001);
    pulse_start();
    step(29);
    pulse_start();
    chk("t4_busy",  32'(bus.o_busy), 32'h1);
    chk("t4_count", 32'(bus.o_hist_count), 32'h2);
    seen = 1'b0;
    for (int i = 1; i <= 67; i++) begin
      step(1);
      seen = seen | bus.o_done;
    end
    chk("t4_no_early_done", 32'(seen), 32'h0);
    step(1);
    chk("t4_done_e68", 32'(bus.o_done), 32'h1);
    step(1);
    chk("t4_count_after", 32'(bus.o_hist_count), 32'h3);

    // 5. zero seed maps to default; seed load while busy is ignored
    load_seed(16'h0000);
    chk("t5_zero_seed", 32'(bus.o_random_out), 32'h1);
    pulse_start();
    chk("t5_start_out", 32'(bus.o_random_out), 32'h2);
    load_seed(16'h000F);
    chk("t5_busy_load_ignored", 32'(bus.o_random_out), 32'h2);
    chk("t5_busy", 32'(bus.o_busy), 32'h1);
    bus.i_stop = 1'b1;
    step(1);
    bus.i_stop = 1'b0;
    chk("t5_done", 32'(bus.o_done), 32'h1);
    step(1);
    chk("t5_count", 32'(bus.o_hist_count), 32'h4);
    hist_at(0, 4'h2, "t5_hist0");
    hist_at(3, 4'h0, "t5_hist3");

    // 6. five complete rolls; count stays saturated, history newest first
    for (int r = 0; r < 5; r++) begin
      load_seed(seeds[r]);
      pulse_start();
      step(67);
      chk("t6_not_done_e67", 32'(bus.o_done), 32'h0);
      step(1);
      chk("t6_done_e68", 32'(bus.o_done), 32'h1);
      chk("t6_result", 32'(bus.o_random_out), 32'(res[r]));
      step(1);
      chk("t6_count_sat", 32'(bus.o_hist_count), 32'h4);
    end
    hist_at(0, 4'h6, "t6_hist0");
    hist_at(1, 4'h5, "t6_hist1");
    hist_at(2, 4'h1, "t6_hist2");
    hist_at(3, 4'h8, "t6_hist3");

    // 7. reset in the middle of a roll
    load_seed(16'h0100);
    pulse_start();
    step(20);
    chk("t7_mid_out", 32'(bus.o_random_out), 32'h5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t7_out",   32'(bus.o_random_out), 32'h1);
    chk("t7_busy",  32'(bus.o_busy), 32'h0);
    chk("t7_done",  32'(bus.o_done), 32'h0);
    chk("t7_count", 32'(bus.o_hist_count), 32'h0);
    hist_at(0, 4'h0, "t7_hist0");
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step(1);
      seen = seen | bus.o_done | bus.o_busy;
    end
    chk("t7_stays_idle", 32'(seen), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
